imem_boot_loader: RTL and testbench

- Sequences program load into instruction memory before the single-cycle core runs.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one write per word to the instruction memory write port.
- Holds the core stalled via core_hold, which drives the PC's pc_write low, until the image is complete.
- Owns the instruction memory write path and the core run/stall decision.

---
 rtl/imem_boot_loader_pkg.sv | 19 +
 rtl/boot_word_assembler.sv | 36 +++
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 tb/tb_imem_boot_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } boot_state_t;

    // Length header is two bytes, little-endian, counting words.
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = 8 * HDR_BYTES;

endpackage

// File: rtl/boot_word_assembler.sv
// Collects stream bytes little-endian into one instruction word.
module boot_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [7:0]                    data_byte,
    output logic                          word_full,
    output logic [8*BYTES_PER_WORD-1:0]   word
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx;

    // The push carrying the last byte of a word completes it.
    assign word_full = push && (idx == IDX_W'(BYTES_PER_WORD - 1));

    // Byte lane insert and wrapping byte index.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx  <= '0;
            word <= '0;
        end else if (push) begin
            for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
                if (idx == IDX_W'(k)) begin
                    word[8*k +: 8] <= data_byte;
                end
            end
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory and
// keeps the core stalled until the whole image has been written.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    boot_state_t       state;
    boot_state_t       state_n;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_full;
    logic [LEN_W:0]    wc_next;
    logic [ADDR_W-1:0] waddr;
    logic              xfer;
    logic              len_bad;
    logic              honour_start;
    logic              asm_clear;
    logic              asm_push;
    logic              word_full;
    logic [31:0]       asm_word;

    assign xfer     = byte_valid && byte_ready;
    assign len_full = {byte_data, len[7:0]};
    assign len_bad  = (len_full == '0) ||
                      ((LEN_W+1)'(len_full) > (LEN_W+1)'(IMEM_WORDS));
    assign wc_next  = (LEN_W+1)'(word_count) + (LEN_W+1)'(1);
    assign asm_push = xfer && (state == DATA);

    // The assembled register already holds all four bytes while in WRITE.
    assign imem_wdata = asm_word;
    assign imem_waddr = waddr;

    boot_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .push      (asm_push),
        .data_byte (byte_data),
        .word_full (word_full),
        .word      (asm_word)
    );

    // Next-state decision for the load sequencer.
    always_comb begin
        state_n      = state;
        honour_start = 1'b0;
        asm_clear    = 1'b0;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_n      = LEN_LO;
                    honour_start = 1'b1;
                    asm_clear    = 1'b1;
                end
            end
            LEN_LO: begin
                if (xfer) state_n = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) begin
                    state_n   = len_bad ? ERROR : DATA;
                    asm_clear = 1'b1;
                end
            end
            DATA: begin
                if (word_full) state_n = WRITE;
            end
            WRITE: begin
                state_n = (wc_next == (LEN_W+1)'(len)) ? DONE : DATA;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, length/address/count registers and outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            waddr      <= '0;
            word_count <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            core_hold  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            byte_ready <= (state_n == LEN_LO) || (state_n == LEN_HI) || (state_n == DATA);
            busy       <= (state_n == LEN_LO) || (state_n == LEN_HI) ||
                          (state_n == DATA)   || (state_n == WRITE);
            imem_we    <= (state_n == WRITE);
            done       <= (state_n == DONE);
            error      <= (state_n == ERROR);
            core_hold  <= (state_n != DONE);

            if (honour_start) begin
                word_count <= '0;
            end
            if (state == LEN_LO && xfer) begin
                len[7:0] <= byte_data;
            end
            if (state == LEN_HI && xfer) begin
                len[15:8] <= byte_data;
                waddr     <= '0;
            end
            if (state == WRITE) begin
                word_count <= word_count + (ADDR_W+1)'(1);
                if (state_n == DATA) begin
                    waddr <= waddr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a
// word-level reference model (expected write list per image).
module tb_imem_boot_loader;

    localparam int unsigned IMEM_WORDS = 256;
    localparam int unsigned ADDR_W     = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int unsigned checks;
    int unsigned errors;
    int unsigned we_count;

    logic [31:0] img_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] mon_a;
    logic [31:0] mon_d;

    imem_boot_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every write strobe must match the next entry of the expected write list.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count++;
            if (exp_addr.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                check("we_addr", 32'(imem_waddr), mon_a);
                check("we_data", imem_wdata, mon_d);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit ok;
        byte_valid = 1'b0;
        for (int unsigned i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            check("gap_ready", 32'(byte_ready), 32'd1);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each byte.
    task automatic run_load(input int unsigned len, input int gap, input bit poke_start);
        int unsigned base;
        int unsigned g;
        bit          legal;
        bit          seen;
        logic [31:0] w;
        legal = (len != 0) && (len <= IMEM_WORDS);
        base  = we_count;
        if (legal) begin
            for (int unsigned i = 0; i < len; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(img_q[i]);
            end
        end
        pulse_start();
        check("start_wc_clear", 32'(word_count), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_err_clear", 32'(error), 32'd0);
        check("start_hold", 32'(core_hold), 32'd1);
        send_byte(len[7:0], 0);
        send_byte(len[15:8], 0);
        if (!legal) begin
            @(negedge clk);
            check("bad_len_error", 32'(error), 32'd1);
            check("bad_len_hold", 32'(core_hold), 32'd1);
            check("bad_len_done", 32'(done), 32'd0);
            byte_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("bad_len_ready", 32'(byte_ready), 32'd0);
            end
            byte_valid = 1'b0;
            check("bad_len_no_we", we_count - base, 32'd0);
            return;
        end
        for (int unsigned wi = 0; wi < len; wi++) begin
            w = img_q[wi];
            for (int unsigned k = 0; k < 4; k++) begin
                g = (gap < 0) ? $urandom_range(0, 3) : gap;
                send_byte(w[8*k +: 8], g);
                if (poke_start && wi == 0 && k == 1) begin
                    pulse_start();
                    check("poke_busy", 32'(busy), 32'd1);
                end
                if (k == 3) begin
                    @(negedge clk);
                    check("we_latency", 32'(imem_we), 32'd1);
                end
            end
        end
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_hold", 32'(core_hold), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_wc", 32'(word_count), len);
        check("done_writes", we_count - base, len);
        check("writes_left", exp_addr.size(), 32'd0);
    endtask

    task automatic fill_random(input int unsigned n);
        img_q.delete();
        for (int unsigned i = 0; i < n; i++) img_q.push_back($urandom);
    endtask

    initial begin
        int unsigned base;
        checks     = 0;
        errors     = 0;
        we_count   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);

        // Idle with noise on the byte input: nothing may be accepted.
        for (int i = 0; i < 20; i++) begin
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            @(negedge clk);
            check("idle_hold", 32'(core_hold), 32'd1);
            check("idle_ready", 32'(byte_ready), 32'd0);
            check("idle_we", 32'(imem_we), 32'd0);
            check("idle_wc", 32'(word_count), 32'd0);
        end
        byte_valid = 1'b0;

        img_q = '{32'h00A00513, 32'h00100593};
        run_load(2, 0, 1'b0);
        run_load(2, 3, 1'b0);

        run_load(0, 0, 1'b0);
        run_load(257, 0, 1'b0);
        fill_random(1);
        run_load(1, 0, 1'b0);

        fill_random(3);
        run_load(3, 0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            int unsigned n;
            n = $urandom_range(1, 12);
            fill_random(n);
            run_load(n, -1, 1'b0);
        end

        fill_random(IMEM_WORDS);
        run_load(IMEM_WORDS, 0, 1'b0);
        check("max_last_addr", 32'(imem_waddr), IMEM_WORDS - 1);

        // Reset after six payload bytes: only word 0 may have been written.
        fill_random(3);
        base = we_count;
        exp_addr.push_back(0);
        exp_data.push_back(img_q[0]);
        pulse_start();
        send_byte(8'd3, 0);
        send_byte(8'd0, 0);
        for (int unsigned k = 0; k < 6; k++) begin
            logic [31:0] w;
            w = img_q[k / 4];
            send_byte(w[8*(k%4) +: 8], 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_hold", 32'(core_hold), 32'd1);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_wc", 32'(word_count), 32'd0);
        check("mid_rst_waddr", 32'(imem_waddr), 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        for (int i = 0; i < 10; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(negedge clk);
            check("mid_rst_idle_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        check("mid_rst_writes", we_count - base, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
